// File: rtl/wasm_data_loader.sv
// Instantiation-time data-segment loader: bounds-checks each segment against the
// initial memory size and streams its bytes into linear memory one per cycle.
package wasm_pkg;
    parameter int unsigned MEMORY_PAGES = 4;

    typedef enum logic [1:0] {
        TRAP_NONE          = 2'd0,
        TRAP_OUT_OF_BOUNDS = 2'd1
    } trap_t;
endpackage

module wasm_data_loader #(
    parameter int unsigned MAX_PAGES      = wasm_pkg::MEMORY_PAGES,
    parameter int unsigned PAGE_SIZE_LOG2 = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [31:0]         cfg_init_pages,
    input  logic [31:0]         cfg_max_pages,
    input  logic                desc_valid,
    output logic                desc_ready,
    input  logic [31:0]         desc_offset,
    input  logic [31:0]         desc_length,
    input  logic                desc_last,
    input  logic                byte_valid,
    output logic                byte_ready,
    input  logic [7:0]          byte_data,
    output logic                init_en,
    output logic [31:0]         init_pages,
    output logic [31:0]         init_max_pages,
    output logic                data_wr_en,
    output logic [31:0]         data_wr_addr,
    output logic [7:0]          data_wr_data,
    output logic                busy,
    output logic                done,
    output wasm_pkg::trap_t     trap,
    output logic [31:0]         bytes_written
);
    import wasm_pkg::*;

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT,
        S_DESC,
        S_COPY,
        S_FINISH
    } state_t;

    state_t      state;
    logic [31:0] seg_addr;
    logic [31:0] remaining;
    logic        seg_last;

    logic [32:0] seg_end;
    logic [47:0] mem_limit;
    logic        seg_oob;
    logic        cfg_bad;

    assign desc_ready = (state == S_DESC);
    assign byte_ready = (state == S_COPY);
    assign busy       = (state != S_IDLE);

    // 33-bit end catches offset+length wrap; 48-bit limit holds any page count.
    always_comb begin
        seg_end   = {1'b0, desc_offset} + {1'b0, desc_length};
        mem_limit = {16'b0, init_pages} << PAGE_SIZE_LOG2;
        seg_oob   = seg_end[32] || ({15'b0, seg_end} > mem_limit);
        cfg_bad   = (cfg_init_pages > MAX_PAGES) ||
                    ((cfg_max_pages != '0) && (cfg_init_pages > cfg_max_pages));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= S_IDLE;
            seg_addr       <= '0;
            remaining      <= '0;
            seg_last       <= 1'b0;
            init_en        <= 1'b0;
            init_pages     <= '0;
            init_max_pages <= '0;
            data_wr_en     <= 1'b0;
            data_wr_addr   <= '0;
            data_wr_data   <= '0;
            done           <= 1'b0;
            trap           <= TRAP_NONE;
            bytes_written  <= '0;
        end else begin
            init_en    <= 1'b0;
            data_wr_en <= 1'b0;
            done       <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        init_pages     <= cfg_init_pages;
                        init_max_pages <= cfg_max_pages;
                        bytes_written  <= '0;
                        if (cfg_bad) begin
                            trap  <= TRAP_OUT_OF_BOUNDS;
                            done  <= 1'b1;
                            state <= S_FINISH;
                        end else begin
                            trap    <= TRAP_NONE;
                            init_en <= 1'b1;
                            state   <= S_INIT;
                        end
                    end
                end
                S_INIT: state <= S_DESC;
                S_DESC: begin
                    if (desc_valid) begin
                        if (seg_oob) begin
                            trap  <= TRAP_OUT_OF_BOUNDS;
                            done  <= 1'b1;
                            state <= S_FINISH;
                        end else if (desc_length == '0) begin
                            if (desc_last) begin
                                done  <= 1'b1;
                                state <= S_FINISH;
                            end
                        end else begin
                            seg_addr  <= desc_offset;
                            remaining <= desc_length;
                            seg_last  <= desc_last;
                            state     <= S_COPY;
                        end
                    end
                end
                S_COPY: begin
                    if (byte_valid) begin
                        data_wr_en    <= 1'b1;
                        data_wr_addr  <= seg_addr;
                        data_wr_data  <= byte_data;
                        seg_addr      <= seg_addr + 32'd1;
                        remaining     <= remaining - 32'd1;
                        bytes_written <= bytes_written + 32'd1;
                        if (remaining == 32'd1) begin
                            if (seg_last) begin
                                done  <= 1'b1;
                                state <= S_FINISH;
                            end else begin
                                state <= S_DESC;
                            end
                        end
                    end
                end
                S_FINISH: state <= S_IDLE;
                default:  state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_wasm_data_loader.sv
// Directed bench for wasm_data_loader: normal loads, bounds traps, config traps and reset abort.
module tb_wasm_data_loader;
    import wasm_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] cfg_init_pages, cfg_max_pages;
    logic        desc_valid, desc_ready, desc_last;
    logic [31:0] desc_offset, desc_length;
    logic        byte_valid, byte_ready;
    logic [7:0]  byte_data;
    logic        init_en;
    logic [31:0] init_pages, init_max_pages;
    logic        data_wr_en;
    logic [31:0] data_wr_addr;
    logic [7:0]  data_wr_data;
    logic        busy, done;
    trap_t       trap;
    logic [31:0] bytes_written;

    int checks = 0;
    int errors = 0;

    wasm_data_loader #(.MAX_PAGES(4), .PAGE_SIZE_LOG2(16)) dut (
        .clk(clk), .rst(rst), .start(start),
        .cfg_init_pages(cfg_init_pages), .cfg_max_pages(cfg_max_pages),
        .desc_valid(desc_valid), .desc_ready(desc_ready),
        .desc_offset(desc_offset), .desc_length(desc_length), .desc_last(desc_last),
        .byte_valid(byte_valid), .byte_ready(byte_ready), .byte_data(byte_data),
        .init_en(init_en), .init_pages(init_pages), .init_max_pages(init_max_pages),
        .data_wr_en(data_wr_en), .data_wr_addr(data_wr_addr), .data_wr_data(data_wr_data),
        .busy(busy), .done(done), .trap(trap), .bytes_written(bytes_written)
    );

    always #5 clk = ~clk;

    // Passive monitor: logs writes and counts pulses, sampled mid-cycle.
    int          cyc = 0;
    int          wr_n = 0, init_n = 0, done_n = 0, brdy_n = 0;
    logic [31:0] wr_addr [0:63];
    logic [7:0]  wr_data [0:63];
    int          wr_cyc  [0:63];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (data_wr_en && wr_n < 64) begin
            wr_addr[wr_n] = data_wr_addr;
            wr_data[wr_n] = data_wr_data;
            wr_cyc[wr_n]  = cyc;
            wr_n = wr_n + 1;
        end
        if (init_en)    init_n = init_n + 1;
        if (done)       done_n = done_n + 1;
        if (byte_ready) brdy_n = brdy_n + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [31:0] ip, input logic [31:0] mp);
        start = 1'b1; cfg_init_pages = ip; cfg_max_pages = mp;
        tick();
        start = 1'b0;
    endtask

    task automatic send_desc(input logic [31:0] off, input logic [31:0] len, input logic last);
        int n = 0;
        desc_valid = 1'b1; desc_offset = off; desc_length = len; desc_last = last;
        while (!desc_ready && n < 50) begin tick(); n++; end
        if (n >= 50) check("desc_timeout", 32'd1, 32'd0);
        tick();
        desc_valid = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic gap);
        int n = 0;
        if (gap) begin byte_valid = 1'b0; tick(); end
        byte_valid = 1'b1; byte_data = b;
        while (!byte_ready && n < 50) begin tick(); n++; end
        if (n >= 50) check("byte_timeout", 32'd1, 32'd0);
        tick();
        byte_valid = 1'b0;
    endtask

    int w0, i0, d0, b0;

    initial begin
        rst = 1'b1; start = 1'b0; cfg_init_pages = '0; cfg_max_pages = '0;
        desc_valid = 1'b0; desc_offset = '0; desc_length = '0; desc_last = 1'b0;
        byte_valid = 1'b0; byte_data = '0;
        tick(); tick();
        rst = 1'b0;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_trap", 32'(trap), 32'(TRAP_NONE));
        check("rst_bytes", bytes_written, 32'd0);
        check("rst_wr_en", 32'(data_wr_en), 32'd0);

        // Single 4-byte segment at 0x10
        w0 = wr_n; i0 = init_n;
        do_start(32'd1, 32'd0);
        check("t1_init_en", 32'(init_en), 32'd1);
        check("t1_init_pages", init_pages, 32'd1);
        tick();
        check("t1_init_en_off", 32'(init_en), 32'd0);
        send_desc(32'h10, 32'd4, 1'b1);
        send_byte(8'hAA, 1'b0); send_byte(8'hBB, 1'b0);
        send_byte(8'hCC, 1'b0); send_byte(8'hDD, 1'b0);
        check("t1_done", 32'(done), 32'd1);
        check("t1_last_wr_en", 32'(data_wr_en), 32'd1);
        tick();
        check("t1_done_off", 32'(done), 32'd0);
        check("t1_trap", 32'(trap), 32'(TRAP_NONE));
        check("t1_bytes", bytes_written, 32'd4);
        check("t1_init_pulses", 32'(init_n - i0), 32'd1);
        check("t1_nwr", 32'(wr_n - w0), 32'd4);
        check("t1_a0", wr_addr[w0],   32'h10); check("t1_d0", 32'(wr_data[w0]),   32'hAA);
        check("t1_a1", wr_addr[w0+1], 32'h11); check("t1_d1", 32'(wr_data[w0+1]), 32'hBB);
        check("t1_a2", wr_addr[w0+2], 32'h12); check("t1_d2", 32'(wr_data[w0+2]), 32'hCC);
        check("t1_a3", wr_addr[w0+3], 32'h13); check("t1_d3", 32'(wr_data[w0+3]), 32'hDD);

        // Two segments with byte_valid gaps, ending at the last byte of page 0
        w0 = wr_n;
        do_start(32'd1, 32'd0); tick();
        send_desc(32'h0, 32'd2, 1'b0);
        send_byte(8'h11, 1'b0); send_byte(8'h22, 1'b1);
        send_desc(32'hFFFE, 32'd2, 1'b1);
        send_byte(8'h33, 1'b0); send_byte(8'h44, 1'b1);
        check("t2_done", 32'(done), 32'd1);
        tick();
        check("t2_trap", 32'(trap), 32'(TRAP_NONE));
        check("t2_bytes", bytes_written, 32'd4);
        check("t2_nwr", 32'(wr_n - w0), 32'd4);
        check("t2_a1", wr_addr[w0+1], 32'h1);
        check("t2_a3", wr_addr[w0+3], 32'hFFFF);
        check("t2_d3", 32'(wr_data[w0+3]), 32'h44);
        check("t2_gap0", 32'(wr_cyc[w0+1] - wr_cyc[w0]), 32'd2);
        check("t2_gap1", 32'(wr_cyc[w0+3] - wr_cyc[w0+2]), 32'd2);

        // Segment crossing the end of memory by one byte
        w0 = wr_n; b0 = brdy_n; d0 = done_n;
        do_start(32'd1, 32'd0); tick();
        send_desc(32'hFFFF, 32'd2, 1'b0);
        check("t3_done", 32'(done), 32'd1);
        check("t3_trap", 32'(trap), 32'(TRAP_OUT_OF_BOUNDS));
        tick(); tick();
        check("t3_nwr", 32'(wr_n - w0), 32'd0);
        check("t3_byte_ready", 32'(brdy_n - b0), 32'd0);
        check("t3_done_pulses", 32'(done_n - d0), 32'd1);
        check("t3_bytes", bytes_written, 32'd0);

        // 33-bit overflow of offset+length
        do_start(32'd1, 32'd0); tick();
        send_desc(32'hFFFF_FFFF, 32'd2, 1'b1);
        check("t4_wrap_trap", 32'(trap), 32'(TRAP_OUT_OF_BOUNDS));
        tick();
        // Zero-length segment exactly at the limit is legal; start clears the trap
        do_start(32'd1, 32'd0);
        check("t4_trap_cleared", 32'(trap), 32'(TRAP_NONE));
        tick();
        send_desc(32'h10000, 32'd0, 1'b1);
        check("t4_zero_done", 32'(done), 32'd1);
        check("t4_zero_trap", 32'(trap), 32'(TRAP_NONE));
        tick();

        // Config traps: above the memory cap, and above the declared max
        i0 = init_n;
        do_start(32'd5, 32'd0);
        check("t5a_done", 32'(done), 32'd1);
        check("t5a_trap", 32'(trap), 32'(TRAP_OUT_OF_BOUNDS));
        tick();
        check("t5a_idle", 32'(busy), 32'd0);
        do_start(32'd3, 32'd2);
        check("t5b_done", 32'(done), 32'd1);
        check("t5b_trap", 32'(trap), 32'(TRAP_OUT_OF_BOUNDS));
        tick();
        check("t5_no_init", 32'(init_n - i0), 32'd0);

        // Reset after 3 of 8 bytes, then a clean rerun
        do_start(32'd1, 32'd0); tick();
        send_desc(32'h100, 32'd8, 1'b1);
        send_byte(8'h01, 1'b0); send_byte(8'h02, 1'b0); send_byte(8'h03, 1'b0);
        w0 = wr_n;
        byte_valid = 1'b1; byte_data = 8'h04; rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t6_busy", 32'(busy), 32'd0);
        check("t6_wr_en", 32'(data_wr_en), 32'd0);
        check("t6_wr_addr", data_wr_addr, 32'd0);
        check("t6_bytes", bytes_written, 32'd0);
        check("t6_byte_ready", 32'(byte_ready), 32'd0);
        check("t6_init_pages", init_pages, 32'd0);
        tick(); tick();
        byte_valid = 1'b0;
        check("t6_no_more_wr", 32'(wr_n - w0), 32'd1);
        w0 = wr_n;
        do_start(32'd1, 32'd0); tick();
        send_desc(32'h20, 32'd2, 1'b1);
        send_byte(8'h55, 1'b0); send_byte(8'h66, 1'b0);
        check("t6_rerun_done", 32'(done), 32'd1);
        tick();
        check("t6_rerun_bytes", bytes_written, 32'd2);
        check("t6_rerun_a0", wr_addr[w0], 32'h20);
        check("t6_rerun_trap", 32'(trap), 32'(TRAP_NONE));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
